// File: rtl/mips_id_pipe_pkg.sv
// Opcode/function constants and the instruction-field decode shared by the ID stage.
package mips_id_pipe_pkg;

  localparam logic [5:0] OP_R_FORM = 6'h00;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_SIGN,
    IMM_ZERO,
    IMM_UPPER
  } imm_kind_e;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] func;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wadr;
    logic       we;
    logic       isload;
    logic       uses_rt;
    imm_kind_e  imm_kind;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    logic r_form;
    logic we_raw;
    d.op   = ins[31:26];
    d.func = ins[5:0];
    d.rs   = ins[25:21];
    d.rt   = ins[20:16];
    r_form = (d.op == OP_R_FORM);

    if (d.op == OP_JAL)  d.wadr = REG_RA;
    else if (r_form)     d.wadr = ins[15:11];
    else                 d.wadr = ins[20:16];

    // JALR links through rd; the excluded functions produce no GPR result.
    we_raw = (r_form && ((d.func == FN_JALR) ||
                         !(d.func inside {FN_JR, FN_MTHI, FN_MTLO, FN_MULT,
                                          FN_MULTU, FN_DIV, FN_DIVU})))
          || ((d.op >= OP_ADDI) && (d.op <= OP_LUI))
          || (d.op == OP_LW) || (d.op == OP_JAL);
    d.we      = we_raw && (d.wadr != 5'd0);
    d.isload  = (d.op == OP_LW);
    d.uses_rt = r_form || (d.op == OP_SW) || (d.op == OP_BEQ) || (d.op == OP_BNE);

    case (d.op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LW, OP_SW, OP_BEQ, OP_BNE:  d.imm_kind = IMM_SIGN;
      OP_ANDI, OP_ORI, OP_XORI:      d.imm_kind = IMM_ZERO;
      OP_LUI:                        d.imm_kind = IMM_UPPER;
      default:                       d.imm_kind = IMM_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// NREG x DW register file, two read ports with write-through bypass, synchronous clear.
module mips_regfile #(
  parameter int DW       = 32,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          we_i,
  input  logic [AW-1:0] wadr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] radr1_i,
  input  logic [AW-1:0] radr2_i,
  output logic [DW-1:0] rdata1_o,
  output logic [DW-1:0] rdata2_o
);

  logic [DW-1:0] regs_q [NREG];
  logic          wr_ok;

  assign wr_ok = we_i && !((ZERO_REG != 0) && (wadr_i == '0));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wadr_i] <= wdata_i;
    end
  end

  // A read of the register being written this cycle sees the new value.
  always_comb begin
    rdata1_o = regs_q[radr1_i];
    rdata2_o = regs_q[radr2_i];
    if ((ZERO_REG != 0) && (radr1_i == '0)) rdata1_o = '0;
    if ((ZERO_REG != 0) && (radr2_i == '0)) rdata2_o = '0;
    if (wr_ok && (wadr_i == radr1_i)) rdata1_o = wdata_i;
    if (wr_ok && (wadr_i == radr2_i)) rdata2_o = wdata_i;
  end

endmodule

// File: rtl/mips_id_pipe.sv
// MIPS instruction-decode stage: decode, operand fetch, immediate extension and
// the ID/EX pipeline register with load-use bubbling, flush and held-operand refresh.
module mips_id_pipe
  import mips_id_pipe_pkg::*;
#(
  parameter int DW       = 32,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IF_VALID,
  input  logic [31:0]   IF_INS,
  input  logic [31:0]   IF_PC,
  output logic          ID_READY,
  input  logic          WB_WE,
  input  logic [AW-1:0] WB_WADR,
  input  logic [DW-1:0] WB_WDATA,
  input  logic          FLUSH,
  input  logic          EX_READY,
  output logic          EX_VALID,
  output logic [5:0]    EX_OP,
  output logic [5:0]    EX_FUNC,
  output logic [4:0]    EX_RS,
  output logic [4:0]    EX_RT,
  output logic [DW-1:0] EX_RDATA1,
  output logic [DW-1:0] EX_RDATA2,
  output logic [DW-1:0] EX_IMM,
  output logic [4:0]    EX_WADR,
  output logic          EX_WE,
  output logic          EX_ISLOAD,
  output logic [31:0]   EX_PC
);

  // Handshake: IF transfers when IF_VALID && ID_READY at the edge; ID/EX transfers
  // when EX_VALID && EX_READY. A valid ID/EX entry stays put until EX takes it.

  dec_t          dec;
  logic [DW-1:0] imm;
  logic [DW-1:0] rdata1, rdata2;
  logic          hazard;

  logic          valid_q, valid_d;
  logic [5:0]    op_q, op_d, func_q, func_d;
  logic [4:0]    rs_q, rs_d, rt_q, rt_d, wadr_q, wadr_d;
  logic [DW-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
  logic          we_q, we_d, isload_q, isload_d;
  logic [31:0]   pc_q, pc_d;

  assign dec = decode(IF_INS);

  always_comb begin
    imm = '0;
    case (dec.imm_kind)
      IMM_SIGN:  imm = {{(DW-16){IF_INS[15]}}, IF_INS[15:0]};
      IMM_ZERO:  imm[15:0] = IF_INS[15:0];
      IMM_UPPER: imm[31:0] = {IF_INS[15:0], 16'h0000};
      default:   imm = '0;
    endcase
  end

  mips_regfile #(
    .DW       (DW),
    .NREG     (NREG),
    .ZERO_REG (ZERO_REG)
  ) u_regfile (
    .CLK      (CLK),
    .RST      (RST),
    .we_i     (WB_WE),
    .wadr_i   (WB_WADR),
    .wdata_i  (WB_WDATA),
    .radr1_i  (dec.rs[AW-1:0]),
    .radr2_i  (dec.rt[AW-1:0]),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  assign hazard = valid_q && isload_q && (wadr_q != 5'd0) &&
                  ((wadr_q == dec.rs) || (dec.uses_rt && (wadr_q == dec.rt)));

  assign ID_READY = !RST || (!hazard && (!valid_q || EX_READY));

  always_comb begin
    valid_d  = valid_q;
    op_d     = op_q;
    func_d   = func_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    imm_d    = imm_q;
    wadr_d   = wadr_q;
    we_d     = we_q;
    isload_d = isload_q;
    pc_d     = pc_q;
    if (FLUSH) begin
      valid_d = 1'b0;
    end else if (valid_q && !EX_READY) begin
      // Held operands track writebacks so EX never consumes a stale value.
      if (WB_WE && (WB_WADR == rs_q[AW-1:0]) && (rs_q != 5'd0)) rdata1_d = WB_WDATA;
      if (WB_WE && (WB_WADR == rt_q[AW-1:0]) && (rt_q != 5'd0)) rdata2_d = WB_WDATA;
    end else if (hazard) begin
      valid_d = 1'b0;
    end else begin
      valid_d = IF_VALID;
      if (IF_VALID) begin
        op_d     = dec.op;
        func_d   = dec.func;
        rs_d     = dec.rs;
        rt_d     = dec.rt;
        rdata1_d = rdata1;
        rdata2_d = rdata2;
        imm_d    = imm;
        wadr_d   = dec.wadr;
        we_d     = dec.we;
        isload_d = dec.isload;
        pc_d     = IF_PC;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      valid_q  <= 1'b0;
      op_q     <= '0;
      func_q   <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      wadr_q   <= '0;
      we_q     <= 1'b0;
      isload_q <= 1'b0;
      pc_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      op_q     <= op_d;
      func_q   <= func_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q    <= imm_d;
      wadr_q   <= wadr_d;
      we_q     <= we_d;
      isload_q <= isload_d;
      pc_q     <= pc_d;
    end
  end

  assign EX_VALID  = valid_q;
  assign EX_OP     = op_q;
  assign EX_FUNC   = func_q;
  assign EX_RS     = rs_q;
  assign EX_RT     = rt_q;
  assign EX_RDATA1 = rdata1_q;
  assign EX_RDATA2 = rdata2_q;
  assign EX_IMM    = imm_q;
  assign EX_WADR   = wadr_q;
  assign EX_WE     = we_q;
  assign EX_ISLOAD = isload_q;
  assign EX_PC     = pc_q;

endmodule

// File: tb/tb_mips_id_pipe.sv
// Directed bench for mips_id_pipe: decode/immediates, bypass, load-use bubble,
// hold refresh, flush, register-0 handling and mid-stream reset.
module tb_mips_id_pipe;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IF_VALID;
  logic [31:0]   IF_INS;
  logic [31:0]   IF_PC;
  logic          ID_READY;
  logic          WB_WE;
  logic [AW-1:0] WB_WADR;
  logic [DW-1:0] WB_WDATA;
  logic          FLUSH;
  logic          EX_READY;
  logic          EX_VALID;
  logic [5:0]    EX_OP, EX_FUNC;
  logic [4:0]    EX_RS, EX_RT, EX_WADR;
  logic [DW-1:0] EX_RDATA1, EX_RDATA2, EX_IMM;
  logic          EX_WE, EX_ISLOAD;
  logic [31:0]   EX_PC;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  mips_id_pipe #(.DW(DW), .NREG(32), .ZERO_REG(1)) dut (
    .CLK(CLK), .RST(RST), .IF_VALID(IF_VALID), .IF_INS(IF_INS), .IF_PC(IF_PC),
    .ID_READY(ID_READY), .WB_WE(WB_WE), .WB_WADR(WB_WADR), .WB_WDATA(WB_WDATA),
    .FLUSH(FLUSH), .EX_READY(EX_READY), .EX_VALID(EX_VALID), .EX_OP(EX_OP),
    .EX_FUNC(EX_FUNC), .EX_RS(EX_RS), .EX_RT(EX_RT), .EX_RDATA1(EX_RDATA1),
    .EX_RDATA2(EX_RDATA2), .EX_IMM(EX_IMM), .EX_WADR(EX_WADR), .EX_WE(EX_WE),
    .EX_ISLOAD(EX_ISLOAD), .EX_PC(EX_PC)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_if(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    IF_VALID = v;
    IF_INS   = ins;
    IF_PC    = pc;
  endtask

  task automatic wb(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] data);
    WB_WE    = we;
    WB_WADR  = adr;
    WB_WDATA = data;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    RST = 1'b0; FLUSH = 1'b0; EX_READY = 1'b1;
    set_if(1'b0, 32'h0, 32'h0);
    wb(1'b0, '0, '0);
    tick();
    tick();
    check("rst_id_ready", ID_READY, 1);
    check("rst_ex_valid", EX_VALID, 0);
    check("rst_ex_imm", EX_IMM, 0);
    check("rst_ex_pc", EX_PC, 0);
    RST = 1'b1;

    // immediates
    set_if(1'b1, 32'h2001FFFB, 32'h100);   // ADDI $1,$0,-5
    #1 check("addi_ready", ID_READY, 1);
    tick();
    check("addi_valid", EX_VALID, 1);
    check("addi_imm", EX_IMM, 32'hFFFFFFFB);
    check("addi_wadr", EX_WADR, 1);
    check("addi_we", EX_WE, 1);
    check("addi_op", EX_OP, 6'h08);
    check("addi_pc", EX_PC, 32'h100);
    set_if(1'b1, 32'h34028000, 32'h104);   // ORI $2,$0,0x8000
    tick();
    check("ori_imm", EX_IMM, 32'h00008000);
    check("ori_wadr", EX_WADR, 2);
    set_if(1'b1, 32'h3C031234, 32'h108);   // LUI $3,0x1234
    tick();
    check("lui_imm", EX_IMM, 32'h12340000);
    check("lui_we", EX_WE, 1);

    // same-cycle writeback bypass
    set_if(1'b1, 32'h00632020, 32'h10C);   // ADD $4,$3,$3
    wb(1'b1, 5'd3, 32'hDEADBEEF);
    tick();
    wb(1'b0, '0, '0);
    check("byp_rdata1", EX_RDATA1, 32'hDEADBEEF);
    check("byp_rdata2", EX_RDATA2, 32'hDEADBEEF);
    check("byp_wadr", EX_WADR, 4);
    check("byp_func", EX_FUNC, 6'h20);

    // load-use: one bubble
    set_if(1'b1, 32'h8C020000, 32'h110);   // LW $2,0($0)
    tick();
    check("lw_isload", EX_ISLOAD, 1);
    check("lw_imm", EX_IMM, 0);
    set_if(1'b1, 32'h00402820, 32'h114);   // ADD $5,$2,$0
    #1 check("lu_ready_low", ID_READY, 0);
    tick();
    check("lu_bubble", EX_VALID, 0);
    check("lu_ready_back", ID_READY, 1);
    tick();
    check("lu_issue_valid", EX_VALID, 1);
    check("lu_issue_pc", EX_PC, 32'h114);
    check("lu_issue_wadr", EX_WADR, 5);

    // load then rt-as-destination: no hazard
    set_if(1'b1, 32'h8C020000, 32'h118);
    tick();
    set_if(1'b1, 32'h20020001, 32'h11C);   // ADDI $2,$0,1
    #1 check("nohaz_ready", ID_READY, 1);
    tick();
    check("nohaz_pc", EX_PC, 32'h11C);
    // load then SW reading rt: hazard
    set_if(1'b1, 32'h8C020000, 32'h120);
    tick();
    set_if(1'b1, 32'hAC020000, 32'h124);   // SW $2,0($0)
    #1 check("sw_haz_ready", ID_READY, 0);
    tick();
    check("sw_bubble", EX_VALID, 0);
    tick();
    check("sw_pc", EX_PC, 32'h124);
    check("sw_we", EX_WE, 0);

    // hold with operand refresh
    set_if(1'b1, 32'h00E03020, 32'h128);   // ADD $6,$7,$0
    tick();
    check("hold_rdata1_pre", EX_RDATA1, 0);
    EX_READY = 1'b0;
    set_if(1'b1, 32'h34028000, 32'h12C);
    #1 check("hold_ready", ID_READY, 0);
    tick();
    wb(1'b1, 5'd7, 32'h55);
    tick();
    wb(1'b0, '0, '0);
    tick();
    check("hold_valid", EX_VALID, 1);
    check("hold_pc", EX_PC, 32'h128);
    check("hold_rdata1", EX_RDATA1, 32'h55);
    check("hold_rdata2", EX_RDATA2, 0);
    check("hold_wadr", EX_WADR, 6);
    check("hold_rs", EX_RS, 7);
    EX_READY = 1'b1;
    #1 check("release_ready", ID_READY, 1);
    tick();
    check("release_pc", EX_PC, 32'h12C);

    // flush with concurrent writeback
    set_if(1'b1, 32'h2001FFFB, 32'h130);
    FLUSH = 1'b1;
    wb(1'b1, 5'd8, 32'h12345678);
    tick();
    FLUSH = 1'b0;
    wb(1'b0, '0, '0);
    check("flush_valid", EX_VALID, 0);
    set_if(1'b1, 32'h01084820, 32'h134);   // ADD $9,$8,$8
    tick();
    check("flush_wb_r1", EX_RDATA1, 32'h12345678);
    check("flush_wb_r2", EX_RDATA2, 32'h12345678);
    check("flush_next_pc", EX_PC, 32'h134);

    // register 0 and write-enable decode
    set_if(1'b1, 32'h00005020, 32'h138);   // ADD $10,$0,$0
    wb(1'b1, 5'd0, 32'hFFFFFFFF);
    tick();
    wb(1'b0, '0, '0);
    check("r0_bypass", EX_RDATA1, 0);
    check("r0_we", EX_WE, 1);
    set_if(1'b1, 32'h00005020, 32'h13C);
    tick();
    check("r0_stored", EX_RDATA2, 0);
    set_if(1'b1, 32'h00210020, 32'h140);   // ADD $0,$1,$1
    tick();
    check("rd0_we", EX_WE, 0);
    set_if(1'b1, 32'h00221818, 32'h144);   // MULT with rd=3
    tick();
    check("mult_we", EX_WE, 0);
    check("mult_wadr", EX_WADR, 3);
    set_if(1'b1, 32'h03E00008, 32'h148);   // JR $31
    tick();
    check("jr_we", EX_WE, 0);
    set_if(1'b1, 32'h0C000010, 32'h14C);   // JAL
    tick();
    check("jal_wadr", EX_WADR, 31);
    check("jal_we", EX_WE, 1);
    set_if(1'b1, 32'h1022FFFE, 32'h150);   // BEQ $1,$2,-2
    tick();
    check("beq_imm", EX_IMM, 32'hFFFFFFFE);
    check("beq_we", EX_WE, 0);
    set_if(1'b1, 32'h3803FFFF, 32'h154);   // XORI $3,$0,0xFFFF
    tick();
    check("xori_imm", EX_IMM, 32'h0000FFFF);

    // back-to-back throughput
    for (int i = 0; i < 4; i++) begin
      set_if(1'b1, 32'h2001FFFB, 32'h200 + 32'(4 * i));
      exp_q.push_back(32'h200 + 32'(4 * i));
      tick();
      check("burst_valid", EX_VALID, 1);
      check("burst_pc", EX_PC, exp_q.pop_front());
    end

    // reset in the middle of a hold
    EX_READY = 1'b0;
    set_if(1'b0, 32'h0, 32'h0);
    RST = 1'b0;
    wb(1'b1, 5'd9, 32'hAAAA);
    #1 check("mid_rst_ready", ID_READY, 1);
    tick();
    check("mid_rst_valid", EX_VALID, 0);
    check("mid_rst_pc", EX_PC, 0);
    check("mid_rst_op", EX_OP, 0);
    check("mid_rst_we", EX_WE, 0);
    check("mid_rst_wadr", EX_WADR, 0);
    RST = 1'b1;
    wb(1'b0, '0, '0);
    EX_READY = 1'b1;
    set_if(1'b1, 32'h00632020, 32'h300);   // reads $3
    tick();
    check("post_rst_r3", EX_RDATA1, 0);
    set_if(1'b1, 32'h01094820, 32'h304);   // reads $8, $9
    tick();
    check("post_rst_r8", EX_RDATA1, 0);
    check("post_rst_r9", EX_RDATA2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
